// File: rtl/wbc_mds_pkg.sv
// Shared types and helpers for the MDS coefficient RAM load path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wbc_mds_pkg;

  // MDS bus width and RAM coefficient width.
  localparam int MDS_W  = 64;
  localparam int COEF_W = 32;

  // Load sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mds_wr_state_t;

  // The read path duplicates a coefficient as {w,w}.
  // A well-formed word therefore has identical halves.
  function automatic logic mds_halves_ok(input logic [MDS_W-1:0] data64);
    return data64[MDS_W-1:COEF_W] == data64[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/mds_ram_writer.sv
// Loads 64-bit {w,w} MDS words into the coefficient RAM at sequential addresses and flags halves mismatches.
// Latency: transfer in cycle N gives the RAM write in N+1; the last transfer gives done in N+2.
// Backpressure: mds_ready is high only in RUN with words remaining; no buffering beyond the single registered write.
module mds_ram_writer
  import wbc_mds_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              mds_valid,
  input  logic [MDS_W-1:0]  mds_data,
  output logic              mds_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [COEF_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_mismatch,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  mds_wr_state_t     r_state;
  mds_wr_state_t     w_state_nxt;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [COEF_W-1:0] r_wdata;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_ready;
  logic              w_xfer;
  logic              w_last;

  // Ready depends only on state and remaining count, never on mds_valid.
  assign w_ready = (r_state == RUN) && (r_rem != '0);
  assign w_xfer  = mds_valid && w_ready;
  assign w_last  = w_xfer && (r_rem == REM_ONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero-length load still passes through DRAIN so done keeps its timing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (num_words != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture on start, registered RAM write per transfer, mismatch tracking, done pulse from DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ptr <= base_addr;
            r_rem <= num_words;
            r_err <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          if (w_xfer) begin
            // The low half is written even when the halves disagree.
            r_we    <= 1'b1;
            r_addr  <= r_ptr;
            r_wdata <= mds_data[COEF_W-1:0];
            r_ptr   <= r_ptr + PTR_ONE;
            r_rem   <= r_rem - REM_ONE;
            if (!mds_halves_ok(mds_data)) begin
              r_err <= 1'b1;
              if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
          end
        end
        DRAIN: begin
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mds_ready    = w_ready;
  assign ram_we       = r_we;
  assign ram_addr     = r_addr;
  assign ram_wdata    = r_wdata;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign err_mismatch = r_err;
  assign mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_mds_ram_writer.sv
// Directed bench for mds_ram_writer: basic load, gaps, mismatch, wrap, zero length, start while busy, async reset.
// Latency: inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Backpressure: the bench drives mds_valid directly and checks mds_ready against the expected remaining count.
module tb_mds_ram_writer;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              mds_valid;
  logic [63:0]       mds_data;
  logic              mds_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              busy;
  logic              done;
  logic              err_mismatch;
  logic [CNT_W-1:0]  mismatch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mds_ram_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .mds_valid    (mds_valid),
    .mds_data     (mds_data),
    .mds_ready    (mds_ready),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .busy         (busy),
    .done         (done),
    .err_mismatch (err_mismatch),
    .mismatch_cnt (mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    mds_valid = 1'b1;
    mds_data  = d;
    tick();
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 64'(ram_we), 64'd1);
    chk({tag, "_addr"}, 64'(ram_addr), 64'(a));
    chk({tag, "_data"}, 64'(ram_wdata), 64'(d));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'(ram_we), 64'd0);
    chk({tag, "_addr"}, 64'(ram_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(ram_wdata), 64'd0);
    chk({tag, "_ready"}, 64'(mds_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err_mismatch), 64'd0);
    chk({tag, "_cnt"}, 64'(mismatch_cnt), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    mds_valid = 1'b0;
    mds_data  = '0;

    // Reset values.
    #3;
    chk_all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic back-to-back load of four words at 0x10.
    do_start(8'h10, 9'd4);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_ready0", 64'(mds_ready), 64'd1);
    send(64'hAAAA0001_AAAA0001);
    chk_wr("basic_w0", 8'h10, 32'hAAAA0001);
    send(64'hBBBB0002_BBBB0002);
    chk_wr("basic_w1", 8'h11, 32'hBBBB0002);
    send(64'hCCCC0003_CCCC0003);
    chk_wr("basic_w2", 8'h12, 32'hCCCC0003);
    send(64'hDDDD0004_DDDD0004);
    mds_valid = 1'b0;
    chk_wr("basic_w3", 8'h13, 32'hDDDD0004);
    chk("basic_drain_ready", 64'(mds_ready), 64'd0);
    chk("basic_drain_done", 64'(done), 64'd0);
    tick();
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_done_we", 64'(ram_we), 64'd0);
    chk("basic_err", 64'(err_mismatch), 64'd0);
    tick();
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_idle", 64'(busy), 64'd0);

    // Gaps in mds_valid: 1,0,1,0 with two words.
    do_start(8'h20, 9'd2);
    send(64'h11111111_11111111);
    chk_wr("gap_w0", 8'h20, 32'h11111111);
    mds_valid = 1'b0;
    tick();
    chk("gap_nowrite", 64'(ram_we), 64'd0);
    send(64'h22222222_22222222);
    chk_wr("gap_w1", 8'h21, 32'h22222222);
    chk("gap_ready_rem0", 64'(mds_ready), 64'd0);
    // Keep valid high through DRAIN: it must be ignored.
    tick();
    chk("gap_done", 64'(done), 64'd1);
    chk("gap_ignored_we", 64'(ram_we), 64'd0);
    mds_valid = 1'b0;
    tick();

    // Halves mismatch on the second of three words.
    do_start(8'h30, 9'd3);
    send(64'hCAFEF00D_CAFEF00D);
    chk_wr("mm_w0", 8'h30, 32'hCAFEF00D);
    chk("mm_err0", 64'(err_mismatch), 64'd0);
    send(64'h12345678_9ABCDEF0);
    chk_wr("mm_w1", 8'h31, 32'h9ABCDEF0);
    chk("mm_err1", 64'(err_mismatch), 64'd1);
    chk("mm_cnt1", 64'(mismatch_cnt), 64'd1);
    send(64'h0BADBEEF_0BADBEEF);
    mds_valid = 1'b0;
    chk_wr("mm_w2", 8'h32, 32'h0BADBEEF);
    chk("mm_cnt_hold", 64'(mismatch_cnt), 64'd1);
    tick();
    chk("mm_done", 64'(done), 64'd1);
    chk("mm_err_sticky", 64'(err_mismatch), 64'd1);
    tick();

    // Address wrap; the new start clears the mismatch state.
    do_start(8'hFE, 9'd3);
    chk("wrap_err_clr", 64'(err_mismatch), 64'd0);
    chk("wrap_cnt_clr", 64'(mismatch_cnt), 64'd0);
    send(64'h000000FE_000000FE);
    chk_wr("wrap_w0", 8'hFE, 32'h000000FE);
    send(64'h000000FF_000000FF);
    chk_wr("wrap_w1", 8'hFF, 32'h000000FF);
    send(64'h00000100_00000100);
    mds_valid = 1'b0;
    chk_wr("wrap_w2", 8'h00, 32'h00000100);
    tick();
    chk("wrap_done", 64'(done), 64'd1);
    tick();

    // Zero length: done two cycles after start, no writes.
    do_start(8'h55, 9'd0);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_ready", 64'(mds_ready), 64'd0);
    chk("zero_we0", 64'(ram_we), 64'd0);
    chk("zero_done_early", 64'(done), 64'd0);
    tick();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_we1", 64'(ram_we), 64'd0);
    tick();
    chk("zero_idle", 64'(busy), 64'd0);
    chk("zero_done_pulse", 64'(done), 64'd0);

    // Start while busy is ignored, then reset after two of five writes.
    do_start(8'h40, 9'd5);
    send(64'h40404040_40404040);
    chk_wr("sb_w0", 8'h40, 32'h40404040);
    mds_valid = 1'b0;
    do_start(8'h80, 9'd1);
    chk("sb_busy", 64'(busy), 64'd1);
    chk("sb_nowrite", 64'(ram_we), 64'd0);
    send(64'h41414141_41414141);
    chk_wr("sb_w1", 8'h41, 32'h41414141);
    chk("sb_ready", 64'(mds_ready), 64'd1);
    // Assert reset between edges: outputs must clear without a clock.
    rst_n = 1'b0;
    #1;
    chk_all_zero("amid");
    tick();
    chk("amid_edge_we", 64'(ram_we), 64'd0);
    chk("amid_edge_done", 64'(done), 64'd0);
    rst_n     = 1'b1;
    mds_valid = 1'b0;
    tick();
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_done", 64'(done), 64'd0);
    do_start(8'h50, 9'd1);
    chk("post_run", 64'(busy), 64'd1);
    send(64'h50505050_50505050);
    mds_valid = 1'b0;
    chk_wr("post_w0", 8'h50, 32'h50505050);
    tick();
    chk("post_done_pulse", 64'(done), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mds_ram_writer.md
Name: mds_ram_writer

Overview:
- Inverse of the MDS read path. The read path duplicates a 32-bit RAM word onto the 64-bit MDS bus as {w,w}.
- This block accepts 64-bit MDS words over a valid/ready stream and checks that the two halves are identical.
- It writes the 32-bit coefficient into the MDS coefficient RAM at sequential addresses.
- It is used to load or refresh MDS tables before a white-box round run, and it reports any halves mismatch.

Parameters:
- ADDR_W, 8, RAM address width; the table occupies at most 2**ADDR_W words.
- CNT_W, 8, width of the mismatch counter (saturating).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr, input, ADDR_W: first RAM address; captured on start.
- num_words, input, ADDR_W+1: number of MDS words to write; captured on start.
- mds_valid, input, 1: MDS word present.
- mds_data, input, 64: MDS word; the payload is bits [31:0].
- mds_ready, output, 1: block accepts the word this cycle.
- ram_we, output, 1: RAM write strobe.
- ram_addr, output, ADDR_W: RAM write address.
- ram_wdata, output, 32: RAM write data.
- busy, output, 1: high in RUN and DRAIN.
- done, output, 1: one-cycle pulse when a load completes.
- err_mismatch, output, 1: sticky flag; some accepted word had [63:32] != [31:0].
- mismatch_cnt, output, CNT_W: count of mismatching words; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE;
  - outputs ram_we, ram_addr, ram_wdata, mds_ready, busy, done, err_mismatch, mismatch_cnt all 0;
  - internal remaining count and address pointer 0.
- States are IDLE, RUN, DRAIN.
  - IDLE: start=1 captures ptr<=base_addr and rem<=num_words, clears err_mismatch and mismatch_cnt. Go to RUN if num_words!=0, else go to DRAIN.
  - RUN: mds_ready = (rem!=0), combinational from state and rem. A transfer occurs when mds_valid & mds_ready. On a transfer:
    - register ram_we<=1, ram_addr<=ptr, ram_wdata<=mds_data[31:0];
    - ptr<=ptr+1, which wraps modulo 2**ADDR_W with no error;
    - rem<=rem-1;
    - if mds_data[63:32]!=mds_data[31:0]: err_mismatch<=1 and mismatch_cnt increments, saturating.
  - RUN, no transfer: ram_we<=0. The data is still written on a mismatch, using the low half.
  - RUN exits to DRAIN on the transfer that takes rem from 1 to 0.
  - DRAIN: lasts exactly one cycle, which lets the final ram_we complete. done<=1 for that one cycle, then go to IDLE. done is high in the cycle after DRAIN is entered.
- Latency:
  - a transfer in cycle N produces the RAM write in cycle N+1;
  - back-to-back transfers give one write per cycle;
  - the last transfer in cycle N produces done in cycle N+2;
  - num_words=0 gives start in cycle N and done in cycle N+2, with no writes.
- start while busy is ignored; captured parameters stay unchanged.
- mds_valid outside RUN is ignored and mds_ready=0.
- The stream source must hold mds_data stable while mds_valid=1 and mds_ready=0. The block does not buffer more than the one registered write.
- num_words > 2**ADDR_W is legal. The address wraps and overwrites earlier entries.
- Reset asserted mid-load aborts immediately:
  - no further writes and no done pulse;
  - RAM contents already written are retained, since the RAM itself is not reset.
- busy = (state!=IDLE).

Decomposition:
- Shared package wbc_mds_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the MDS_W=64 and COEF_W=32 constants;
  - a function mds_halves_ok(data64) that returns 1 when the halves are equal.
- No sub-module. The write path is a single registered stage inside this module.

Test Plan:
- Basic load: base_addr=0x10, num_words=4, words {A,A},{B,B},{C,C},{D,D} streamed back-to-back → writes at 0x10..0x13 with data A..D on 4 consecutive cycles; done two cycles after the last transfer; err_mismatch=0.
- Backpressure and gaps: mds_valid toggles 1,0,1,0 with num_words=2 → exactly 2 writes, each one cycle after its transfer; no write in gap cycles; mds_ready drops to 0 once rem=0.
- Mismatch: num_words=3; second word is 0x12345678_9ABCDEF0 → ram_wdata=0x9ABCDEF0 written; err_mismatch=1; mismatch_cnt=1. A new start then clears both.
- Wrap and zero length: ADDR_W=8, base_addr=0xFE, num_words=3 → addresses 0xFE, 0xFF, 0x00. Then num_words=0 → no ram_we and done 2 cycles after start.
- Start while busy and reset mid-load:
  - a second start pulse during RUN changes nothing;
  - rst_n pulled low after 2 of 5 writes → all outputs 0 asynchronously, no done pulse;
  - after release the block is in IDLE and accepts a new start.
